// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC sequencer.
//   state_e  : sequencer FSM states (BOOT, RUN, FLUSH)
//   redir_e  : kind of redirect selected in a cycle (NONE, BR, J, JR)
//   INST_BYTES : fetch stride in bytes
//   redir_kind() : resolves simultaneous redirect requests by priority
package pc_seq_pkg;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

    typedef enum logic [1:0] {NONE, BR, J, JR} redir_e;

    localparam int unsigned INST_BYTES = 4;

    // Priority jr > jump > taken branch; several asserted at once is legal.
    function automatic redir_e redir_kind(input logic jr, input logic jump,
                                          input logic br_taken);
        if (jr)            return JR;
        else if (jump)     return J;
        else if (br_taken) return BR;
        else               return NONE;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundle between decode/ALU control and the PC sequencer.
//   master : decode side, drives stall/redirect requests, reads fetch address
//   slave  : pc_sequencer, reads requests, drives pc_o/pc_plus4_o/inst_valid_o/flush_o
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              stall_i;
    logic              branch_i;
    logic              cond_i;
    logic [15:0]       imm_i;
    logic              jump_i;
    logic [25:0]       jaddr_i;
    logic              jr_i;
    logic [ADDR_W-1:0] rs_data_i;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc_plus4_o;
    logic              inst_valid_o;
    logic              flush_o;

    modport master (
        output stall_i, branch_i, cond_i, imm_i, jump_i, jaddr_i, jr_i, rs_data_i,
        input  pc_o, pc_plus4_o, inst_valid_o, flush_o
    );

    modport slave (
        input  stall_i, branch_i, cond_i, imm_i, jump_i, jaddr_i, jr_i, rs_data_i,
        output pc_o, pc_plus4_o, inst_valid_o, flush_o
    );
endinterface

// File: rtl/pc_sequencer_target_calc.sv
// pc_target_calc: combinational candidate-address generator.
//   pc        in  : current fetch address
//   imm       in  : signed branch offset in words
//   jaddr     in  : jump word index
//   rs_data   in  : register jump target
//   pc_plus4  out : sequential address (modulo 2^ADDR_W)
//   br_target out : pc+4 + (sext(imm) << 2)
//   j_target  out : {pc_plus4[ADDR_W-1:28], jaddr, 2'b00}
//   jr_target out : rs_data with the two low bits cleared
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [15:0]       imm,
    input  logic [25:0]       jaddr,
    input  logic [ADDR_W-1:0] rs_data,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] j_target,
    output logic [ADDR_W-1:0] jr_target
);
    // Region bits above the 256 MB jump window come from pc+4.
    localparam logic [ADDR_W-1:0] REGION_MASK = ~ADDR_W'(28'hFFF_FFFF);

    logic [ADDR_W-1:0] br_offset;

    assign pc_plus4  = pc + ADDR_W'(INST_BYTES);
    assign br_offset = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    assign br_target = pc_plus4 + br_offset;
    assign j_target  = (pc_plus4 & REGION_MASK) | ADDR_W'({jaddr, 2'b00});
    assign jr_target = {rs_data[ADDR_W-1:2], 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and next-fetch-address control.
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active low
//   bus   : pc_sequencer_if.slave (stall/redirect requests in; pc_o,
//           pc_plus4_o, inst_valid_o, flush_o out)
// After a taken redirect the FSM spends FLUSH_CYCLES bubble cycles in FLUSH
// (inst_valid_o=0, flush_o=1 in the first one) while the PC keeps stepping.
// Build option: define PC_SEQ_DELAY_SLOT_EN to replace the flush with a
// one-instruction delay slot backed by a pending-target register.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pc_sequencer_if.slave    bus
);
    state_e            state;
    logic [ADDR_W-1:0] pc_q;
    logic [1:0]        bubble_cnt;
    logic              valid_q;
    logic              flush_q;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] target;
    redir_e            kind;

    pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
        .pc        (pc_q),
        .imm       (bus.imm_i),
        .jaddr     (bus.jaddr_i),
        .rs_data   (bus.rs_data_i),
        .pc_plus4  (pc_plus4),
        .br_target (br_target),
        .j_target  (j_target),
        .jr_target (jr_target)
    );

    assign kind = redir_kind(bus.jr_i, bus.jump_i, bus.branch_i & bus.cond_i);

    // NOTE: default assignment first so every path drives target and no latch is inferred.
    always_comb begin
        target = pc_plus4;
        unique case (kind)
            JR:      target = jr_target;
            J:       target = j_target;
            BR:      target = br_target;
            default: target = pc_plus4;
        endcase
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic [ADDR_W-1:0] pend_target;
    logic              pend_valid;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= BOOT;
            pc_q       <= RESET_PC;
            bubble_cnt <= '0;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
            pend_target <= '0;
            pend_valid  <= 1'b0;
`endif
        end else if (!bus.stall_i) begin
            unique case (state)
                BOOT: begin
                    state   <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
`ifdef PC_SEQ_DELAY_SLOT_EN
                    // The delay-slot cycle consumes the pending target and
                    // ignores any new redirect.
                    if (pend_valid) begin
                        pc_q       <= pend_target;
                        pend_valid <= 1'b0;
                    end else if (kind != NONE) begin
                        pc_q        <= pc_plus4;
                        pend_target <= target;
                        pend_valid  <= 1'b1;
                    end else begin
                        pc_q <= pc_plus4;
                    end
`else
                    if (kind != NONE) begin
                        pc_q       <= target;
                        state      <= FLUSH;
                        flush_q    <= 1'b1;
                        valid_q    <= 1'b0;
                        bubble_cnt <= 2'(FLUSH_CYCLES - 1);
                    end else begin
                        pc_q <= pc_plus4;
                    end
`endif
                end
                FLUSH: begin
                    pc_q    <= pc_plus4;
                    flush_q <= 1'b0;
                    if (bubble_cnt == '0) begin
                        state   <= RUN;
                        valid_q <= 1'b1;
                    end else begin
                        bubble_cnt <= bubble_cnt - 2'd1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.pc_o         = pc_q;
    assign bus.pc_plus4_o   = pc_plus4;
    assign bus.inst_valid_o = valid_q;
    assign bus.flush_o      = flush_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a behavioural model.
// The model tracks the fetch stream as "boot pending / bubbles remaining /
// pending delay-slot target" and is compared against the DUT every cycle;
// directed literal checks pin both the model and the DUT.
// Build option: PC_SEQ_DELAY_SLOT_EN selects the delay-slot scenario.
module tb_pc_sequencer;

    localparam int          ADDR_W       = 32;
    localparam logic [31:0] RESET_PC     = 32'h0040_0000;
    localparam int          FLUSH_CYCLES = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    pc_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

    pc_sequencer #(
        .ADDR_W       (ADDR_W),
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_flush;
    bit          m_booting;
    int          m_bubbles;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    bit          m_taken;
    logic [31:0] m_tgt;
    int          m_off;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc      = RESET_PC;
            m_valid   = 1'b0;
            m_flush   = 1'b0;
            m_booting = 1'b1;
            m_bubbles = 0;
            m_pend    = 1'b0;
        end else if (!bus_if.stall_i) begin
            m_taken = 1'b1;
            m_off   = int'($signed(bus_if.imm_i));
            if (bus_if.jr_i)
                m_tgt = bus_if.rs_data_i & ~32'd3;
            else if (bus_if.jump_i)
                m_tgt = ((m_pc + 32'd4) & 32'hF000_0000) | {4'b0, bus_if.jaddr_i, 2'b00};
            else if (bus_if.branch_i && bus_if.cond_i)
                m_tgt = m_pc + 32'd4 + 32'(m_off * 4);
            else
                m_taken = 1'b0;

            if (m_booting) begin
                m_booting = 1'b0;
                m_valid   = 1'b1;
            end else if (m_bubbles > 0) begin
                m_pc      = m_pc + 32'd4;
                m_flush   = 1'b0;
                m_bubbles = m_bubbles - 1;
                if (m_bubbles == 0) m_valid = 1'b1;
            end else begin
`ifdef PC_SEQ_DELAY_SLOT_EN
                if (m_pend) begin
                    m_pc   = m_pend_tgt;
                    m_pend = 1'b0;
                end else if (m_taken) begin
                    m_pend_tgt = m_tgt;
                    m_pend     = 1'b1;
                    m_pc       = m_pc + 32'd4;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
`else
                if (m_taken) begin
                    m_pc      = m_tgt;
                    m_bubbles = FLUSH_CYCLES;
                    m_flush   = 1'b1;
                    m_valid   = 1'b0;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
`endif
            end
        end
    end

    // Single compare process, mid-cycle away from the active edge.
    always @(negedge clk) begin
        check("model_pc",       bus_if.pc_o,                m_pc);
        check("model_pc_plus4", bus_if.pc_plus4_o,          m_pc + 32'd4);
        check("model_valid",    32'(bus_if.inst_valid_o),   32'(m_valid));
        check("model_flush",    32'(bus_if.flush_o),        32'(m_flush));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic st, input logic br, input logic cd,
                       input logic [15:0] im, input logic jp, input logic [25:0] ja,
                       input logic jrr, input logic [31:0] rs);
        bus_if.stall_i   = st;
        bus_if.branch_i  = br;
        bus_if.cond_i    = cd;
        bus_if.imm_i     = im;
        bus_if.jump_i    = jp;
        bus_if.jaddr_i   = ja;
        bus_if.jr_i      = jrr;
        bus_if.rs_data_i = rs;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    endtask

    task automatic expect_out(input string name, input logic [31:0] pc,
                              input logic valid, input logic flush);
        check({name, "_pc"},    bus_if.pc_o,              pc);
        check({name, "_valid"}, 32'(bus_if.inst_valid_o), 32'(valid));
        check({name, "_flush"}, 32'(bus_if.flush_o),      32'(flush));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.stall_i   = 1'b0;
        bus_if.branch_i  = 1'b0;
        bus_if.cond_i    = 1'b0;
        bus_if.imm_i     = '0;
        bus_if.jump_i    = 1'b0;
        bus_if.jaddr_i   = '0;
        bus_if.jr_i      = 1'b0;
        bus_if.rs_data_i = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", RESET_PC, 1'b0, 1'b0);

        // Boot cycle, then sequential fetch.
        rst_n = 1'b1;
        #1 check("boot_valid", 32'(bus_if.inst_valid_o), 32'd0);
        @(negedge clk);
        expect_out("boot0", 32'h0040_0000, 1'b1, 1'b0);
        idle(); expect_out("seq1", 32'h0040_0004, 1'b1, 1'b0);
        idle(); expect_out("seq2", 32'h0040_0008, 1'b1, 1'b0);

`ifndef PC_SEQ_DELAY_SLOT_EN
        // Move to 0xFC via jr, one bubble, then RUN at 0x100.
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_00FC);
        expect_out("jr_fc", 32'h0000_00FC, 1'b0, 1'b1);
        idle(); expect_out("jr_fc_run", 32'h0000_0100, 1'b1, 1'b0);

        // Backward branch taken.
        cyc(0, 1, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0);
        expect_out("bbr_taken", 32'h0000_00FC, 1'b0, 1'b1);
        idle(); expect_out("bbr_run", 32'h0000_0100, 1'b1, 1'b0);

        // Same branch, condition false.
        cyc(0, 1, 0, 16'hFFFE, 0, 26'h0, 0, 32'h0);
        expect_out("bbr_nt", 32'h0000_0104, 1'b1, 1'b0);

        // jr beats jump; low bits forced to zero.
        cyc(0, 0, 0, 16'h0, 1, 26'h000_0040, 1, 32'h0000_2003);
        expect_out("prio", 32'h0000_2000, 1'b0, 1'b1);
        idle(); expect_out("prio_run", 32'h0000_2004, 1'b1, 1'b0);

        // Jump alone: region from pc+4 (0x2008), index 0x40 -> 0x100.
        cyc(0, 0, 0, 16'h0, 1, 26'h000_0040, 0, 32'h0);
        expect_out("jump", 32'h0000_0100, 1'b0, 1'b1);
        idle(); expect_out("jump_run", 32'h0000_0104, 1'b1, 1'b0);

        // Forward branch: 0x108 + 3*4 = 0x114.
        cyc(0, 1, 1, 16'h0003, 0, 26'h0, 0, 32'h0);
        expect_out("fbr", 32'h0000_0114, 1'b0, 1'b1);
        idle(); expect_out("fbr_run", 32'h0000_0118, 1'b1, 1'b0);

        // Stall for three cycles, taken branch presented in the second.
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        expect_out("stall1", 32'h0000_0118, 1'b1, 1'b0);
        cyc(1, 1, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0);
        expect_out("stall2", 32'h0000_0118, 1'b1, 1'b0);
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        expect_out("stall3", 32'h0000_0118, 1'b1, 1'b0);
        idle(); expect_out("stall_resume", 32'h0000_011C, 1'b1, 1'b0);

        // Stall during FLUSH stretches the bubble; redirect in FLUSH ignored.
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0200);
        expect_out("fl_enter", 32'h0000_0200, 1'b0, 1'b1);
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        expect_out("fl_stall1", 32'h0000_0200, 1'b0, 1'b1);
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        expect_out("fl_stall2", 32'h0000_0200, 1'b0, 1'b1);
        cyc(0, 0, 0, 16'h0, 1, 26'h0000_999, 0, 32'h0);
        expect_out("fl_ignore", 32'h0000_0204, 1'b1, 1'b0);

        // Wrap-around at the top of the address space.
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFF8);
        expect_out("wrap_a", 32'hFFFF_FFF8, 1'b0, 1'b1);
        idle(); expect_out("wrap_b", 32'hFFFF_FFFC, 1'b1, 1'b0);
        check("wrap_plus4", bus_if.pc_plus4_o, 32'h0000_0000);
        idle(); expect_out("wrap_c", 32'h0000_0000, 1'b1, 1'b0);

        // Reset asserted mid-flush takes effect without a clock edge.
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0300);
        expect_out("rf_enter", 32'h0000_0300, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 expect_out("rf_async", RESET_PC, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); expect_out("rf_boot", RESET_PC, 1'b1, 1'b0);
        idle(); expect_out("rf_seq", 32'h0040_0004, 1'b1, 1'b0);
`else
        // jr to 0x40 through the delay slot at 0x40000C.
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0040);
        expect_out("ds_jr_slot", 32'h0040_000C, 1'b1, 1'b0);
        idle(); expect_out("ds_jr_tgt", 32'h0000_0040, 1'b1, 1'b0);

        // Jump 0x40 -> 0x80: slot 0x44 stays valid; jr in the slot is ignored.
        cyc(0, 0, 0, 16'h0, 1, 26'h000_0020, 0, 32'h0);
        expect_out("ds_j_slot", 32'h0000_0044, 1'b1, 1'b0);
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0500);
        expect_out("ds_j_tgt", 32'h0000_0080, 1'b1, 1'b0);
        idle(); expect_out("ds_seq", 32'h0000_0084, 1'b1, 1'b0);

        // Stall holds the pending target until the next free cycle.
        cyc(0, 1, 1, 16'h0010, 0, 26'h0, 0, 32'h0);
        expect_out("ds_br_slot", 32'h0000_0088, 1'b1, 1'b0);
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        expect_out("ds_br_stall", 32'h0000_0088, 1'b1, 1'b0);
        idle(); expect_out("ds_br_tgt", 32'h0000_00C8, 1'b1, 1'b0);
`endif
        idle();
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
